// File: rtl/uart_tx_if.sv
// Byte-write and serial-line signals of the buffered UART transmitter.
// The slave modport is the transmitter side and the master modport is the producer side.
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    din;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;
  logic          mosi;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, din,
    input  full, level, overflow, mosi, busy, done
  );

  modport slave (
    input  wr_en, din,
    output full, level, overflow, mosi, busy, done
  );
endinterface

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small FIFO feeds a serialiser.
// An optional idle gap follows each stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_GAP     = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  uart_tx_if.slave tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          mosi_q, mosi_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;

  logic push, pop, bit_end;

  // full_q is the registered flag, so a write is dropped even if a pop frees a slot this cycle
  assign push    = tx.wr_en && !full_q;
  assign pop     = (state_q == S_IDLE) && (level_q != '0);
  assign bit_end = (clk_cnt_q == 8'(CLKS_PER_BIT - 1));

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = tx.wr_en && full_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx.din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == LW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    clk_cnt_d = bit_end ? 8'd0 : clk_cnt_q + 8'd1;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = 8'd0;
        gap_cnt_d = 4'd0;
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: if (bit_end) state_d = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
      S_GAP: begin
        if (bit_end) begin
          gap_cnt_d = gap_cnt_q + 4'd1;
          if (gap_cnt_q == 4'(IDLE_GAP - 1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // line level is registered, so it follows the state being entered
    case (state_d)
      S_START: mosi_d = 1'b0;
      S_DATA:  mosi_d = shift_d[0];
      default: mosi_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      mosi_q     <= 1'b1;
      shift_q    <= 8'd0;
      clk_cnt_q  <= 8'd0;
      bit_cnt_q  <= 3'd0;
      gap_cnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      mosi_q     <= mosi_d;
      shift_q    <= shift_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // storage needs no reset: the pointers and level define what is valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx.full     = full_q;
  assign tx.level    = level_q;
  assign tx.overflow = overflow_q;
  assign tx.mosi     = mosi_q;
  assign tx.busy     = (state_q != S_IDLE);
  assign tx.done     = (state_q == S_STOP) && bit_end;
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, 1, clock cycles per serial bit; legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, 4, transmit buffer entries; power of two, 2..16.
REQ-003 Parameter IDLE_GAP, 0, extra idle-high bit periods after each stop bit; legal range 0..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 wr_en  input  1  write strobe; pushes din when full is 0.
REQ-007 din  input  8  byte to transmit.
REQ-008 full  output  1  buffer holds FIFO_DEPTH entries.
REQ-009 level  output  clog2(FIFO_DEPTH)+1  number of buffered bytes.
REQ-010 overflow  output  1  one-cycle pulse when wr_en is dropped because full is 1.
REQ-011 mosi  output  1  serial line, registered, idle high; connects directly to uart_rx mosi.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-014 Frame format: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
REQ-015 A write is accepted at an edge where wr_en=1 and the registered full=0. level increments at the same edge.
REQ-016 A write with full=1 is dropped and pulses overflow, even if the FSM pops in the same cycle. Buffer contents are unchanged.
REQ-017 A simultaneous accepted write and pop leaves level unchanged. Ordering is strict FIFO.
REQ-018 FSM states are IDLE, START, DATA, STOP and GAP.
REQ-019 IDLE: mosi=1. If level!=0, pop the head into the shift register, clear the bit counter, and go to START.
REQ-020 START: mosi=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-021 DATA: mosi=shift[0]. After each bit period, shift right and increment the 3-bit counter. After bit 7, go to STOP.
REQ-022 STOP: mosi=1 for CLKS_PER_BIT cycles. Assert done on the final cycle. Go to GAP if IDLE_GAP>0, otherwise to IDLE.
REQ-023 GAP: mosi=1 for IDLE_GAP*CLKS_PER_BIT cycles, then go to IDLE.
REQ-024 Latency: for a write accepted at edge E0 into an empty buffer with the FSM in IDLE, mosi falls at edge E0+1.
REQ-025 Back-to-back frame period is (10+IDLE_GAP)*CLKS_PER_BIT+1 cycles; the IDLE cycle adds one guaranteed high cycle between frames.
REQ-026 The per-bit cycle counter counts 0..CLKS_PER_BIT-1 and wraps. No bit period is ever shortened or lengthened.
REQ-027 When the buffer empties mid-frame, the current frame completes normally and the FSM rests in IDLE with mosi=1.
REQ-028 The shift register is loaded only in IDLE. Writes during a frame never alter the frame in flight.

Reset
REQ-029 On an edge with rst_n=0 the block applies these values: state=IDLE, mosi=1, busy=0, done=0, overflow=0, level=0, full=0, buffer pointers=0, all counters=0.
REQ-030 Reset mid-frame aborts the frame. mosi is 1 from that edge; buffered bytes are discarded.
REQ-031 wr_en is ignored on any edge where rst_n=0.

Verification
REQ-032 Reset: hold rst_n=0 for 3 edges, wr_en=1 -> mosi=1, level=0, busy=0, done=0, overflow=0 throughout.
REQ-033 Single byte, CLKS_PER_BIT=1: write 0xA5 at E0 -> mosi at edges E0+1..E0+10 = 0,1,0,1,0,0,1,0,1,1. done=1 in the cycle after E0+10; busy=0 from E0+11.
REQ-034 CLKS_PER_BIT=3: write 0x01 -> start low for 3 cycles, bit0 high for 3 cycles, bits1..7 low for 21 cycles, stop high for 3 cycles; total 30 cycles.
REQ-035 Overflow, CLKS_PER_BIT=1, FIFO_DEPTH=4: wr_en=1 on 6 consecutive edges with 0x10..0x15 -> 0x10..0x14 accepted, 0x15 dropped with one overflow pulse, level=4 after the 6th edge. Frames are sent in order 0x10..0x14.
REQ-036 Loopback into uart_rx, CLKS_PER_BIT=1, IDLE_GAP=0: write 0x00, 0xFF, 0x3C back-to-back -> three uart_rx ok pulses 11 cycles apart, with data 0x00, 0xFF, 0x3C.
REQ-037 Reset mid-frame: assert rst_n=0 during DATA bit 4 of 0x55 with 2 bytes queued -> mosi=1 and level=0 from that edge, and no done pulse. A subsequent write of 0x80 transmits correctly.
